spi_slave_param: RTL and testbench
==================================

Name: spi_slave_param

Overview:
- Parametrised SPI slave front-end for the SPI-to-single-port-RAM path.
- Sampled on the system clock: one MOSI bit per `clk` edge while `SS_n` is low.
- Generalises the frame to a 2-bit command plus a DATA_W-bit payload, emits `rx_valid` as a one-cycle pulse, and shifts RAM read data out MSB-first on MISO after a `tx_valid` handshake.
- Sits between the external SPI master and the RAM command/data port.

Parameters:
- DATA_W, 8, payload/RAM data width (≥2); frame length FRAME_W = DATA_W+2.
- MISO_IDLE, 0, value driven on MISO when not shifting read data.

Ports:
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `SS_n`  input  1  slave select, active-low; high aborts any frame.
- `MOSI`  input  1  serial data in, MSB first.
- `tx_data`  input  DATA_W  read data from RAM.
- `tx_valid`  input  1  `tx_data` valid strobe.
- `rx_data`  output  FRAME_W  received frame {cmd[1:0], payload}.
- `rx_valid`  output  1  one-cycle pulse: `rx_data` holds a complete frame.
- `MISO`  output  1  serial data out, MSB first.
- `frame_err`  output  1  aborted-frame flag (see Optional Feature).

Behaviour:
- Reset (`rst`=1 at edge): state=IDLE, `rx_data`=0, `rx_valid`=0, `MISO`=MISO_IDLE, `frame_err`=0, `rd_addr_seen`=0, counters=0. Reset overrides everything, including mid-frame.
- Commands (first two frame bits):
  - 00 = write address
  - 01 = write data
  - 10 = read address
  - 11 = read data
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT.
- From any non-IDLE state: `SS_n`=1 at an edge → IDLE next cycle, partial frame discarded, no `rx_valid`, `rd_addr_seen` unchanged, `MISO`=MISO_IDLE.
- IDLE: `SS_n`=0 → CHK_CMD.
- CHK_CMD: samples frame bit 0 (cmd MSB) into the shift register. Next state:
  - MOSI=0 → WRITE
  - MOSI=1 and `rd_addr_seen`=0 → READ_ADD
  - MOSI=1 and `rd_addr_seen`=1 → READ_DATA
- WRITE, READ_ADD and READ_DATA:
  - Each shift one bit per edge until FRAME_W bits are captured; bit counter is $clog2(FRAME_W) wide and saturates.
  - On the edge sampling the last bit, `rx_data` is updated with the full frame and `rx_valid`=1 for exactly that one cycle.
  - After the frame completes, the state holds with no further shifting until `SS_n`=1. Extra MOSI bits are ignored.
  - READ_ADD completion sets `rd_addr_seen`=1.
  - READ_DATA completion → TX_WAIT.
- TX_WAIT:
  - First edge with `tx_valid`=1 latches `tx_data` and drives `MISO`=`tx_data`[DATA_W-1] → TX_SHIFT.
  - `tx_valid` outside TX_WAIT is ignored.
- TX_SHIFT:
  - Drives the next bit each edge; after bit 0 has been driven for one cycle, `MISO`=MISO_IDLE and `rd_addr_seen`=0.
  - Then holds until `SS_n`=1.
  - If `SS_n` rises mid-shift, `rd_addr_seen` remains 1.
- `rx_data` holds its last completed frame between frames.
- Command bit 1 is not checked against the state; the RAM side decodes `rx_data`[FRAME_W-1:FRAME_W-2].

Optional Feature:
- Macro: SPI_SLAVE_FRAME_ERR_EN.
- Defined: `frame_err` pulses 1 for one cycle on the edge where `SS_n`=1 is seen in CHK_CMD/WRITE/READ_ADD/READ_DATA before the frame completes, or in TX_WAIT/TX_SHIFT before the last MISO bit.
- Undefined: `frame_err` is tied to 0 and no detection logic is built.

Test Plan:
- DATA_W=8, reset held 2 cycles → `rx_data`=0x000, `rx_valid`=0, `MISO`=0, state IDLE.
- `SS_n` low, shift 00_1010_0101 → `rx_data`=0x0A5, `rx_valid` high exactly 1 cycle, on the edge sampling bit 9. Repeat with 01_0011_1100 → `rx_data`=0x13C.
- Read sequence:
  - Frame 10_0001_0000 → `rx_data`=0x210, `rd_addr_seen`=1.
  - Next frame 11_xxxx_xxxx → `rx_valid` pulse.
  - `tx_valid`=1 with `tx_data`=0xC3 → MISO=1,1,0,0,0,0,1,1 on consecutive cycles, then 0; a subsequent cmd-1 frame goes to READ_ADD.
- Abort: `SS_n` rises after 5 bits of a write frame → no `rx_valid`, `rx_data` unchanged, IDLE next cycle; `frame_err`=1 pulse with SPI_SLAVE_FRAME_ERR_EN defined, 0 without.
- `rst`=1 asserted during TX_SHIFT bit 3 → next cycle `MISO`=0, `rd_addr_seen`=0, IDLE; `tx_valid` pulse in IDLE is ignored.
- DATA_W=16 regression: frame 01 + 0xBEEF → `rx_data`=0x1BEEF after 18 bits; read-data returns `tx_data`=0x1234 as 16 MSB-first bits.

Source files
------------

// File: rtl/spi_slave_param_if.sv
// Bus bundle between the SPI slave front-end and its environment (SPI master pins plus RAM data port).
interface spi_slave_param_if #(
  parameter int DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, frame_err
  );

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, frame_err
  );
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end for the SPI-to-RAM path, sampled on clk.
// Optional aborted-frame detection on frame_err is built when SPI_SLAVE_FRAME_ERR_EN is defined.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for SS_n low
// CHK_CMD   | sampling cmd MSB, choosing write / read-address / read-data
// WRITE     | shifting a write-address or write-data frame
// READ_ADD  | shifting a read-address frame, arms rd_addr_seen
// READ_DATA | shifting a read-data request frame
// TX_WAIT   | waiting for tx_valid from the RAM
// TX_SHIFT  | driving tx_data onto MISO, MSB first
module spi_slave_param #(
  parameter int   DATA_W    = 8,
  parameter logic MISO_IDLE = 1'b0
) (
  input logic              clk,
  input logic              rst,
  spi_slave_param_if.slave bus
);
  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    TX_WAIT   = 3'd5,
    TX_SHIFT  = 3'd6
  } state_t;

  state_t             state;
  logic [FRAME_W-1:0] rx_shreg;
  logic [FRAME_W-1:0] rx_data_q;
  logic [DATA_W-1:0]  tx_shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               done;
  logic               rx_valid_q;
  logic               miso_q;
  logic               rd_addr_seen;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic               frame_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rx_shreg     <= '0;
      rx_data_q    <= '0;
      tx_shreg     <= '0;
      bit_cnt      <= '0;
      done         <= 1'b0;
      rx_valid_q   <= 1'b0;
      miso_q       <= MISO_IDLE;
      rd_addr_seen <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q  <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
      if (state != IDLE && bus.SS_n) begin
        // done is low exactly while a frame or a read-out is still incomplete
        state   <= IDLE;
        bit_cnt <= '0;
        done    <= 1'b0;
        miso_q  <= MISO_IDLE;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_q <= ~done;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (!bus.SS_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            rx_shreg <= {rx_shreg[FRAME_W-2:0], bus.MOSI};
            bit_cnt  <= CNT_W'(1);
            if (!bus.MOSI)        state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!done) begin
              rx_shreg <= {rx_shreg[FRAME_W-2:0], bus.MOSI};
              if (bit_cnt == LAST_RX) begin
                rx_data_q  <= {rx_shreg[FRAME_W-2:0], bus.MOSI};
                rx_valid_q <= 1'b1;
                if (state == READ_ADD) rd_addr_seen <= 1'b1;
                if (state == READ_DATA) begin
                  state   <= TX_WAIT;
                  bit_cnt <= '0;
                end else begin
                  done <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          TX_WAIT: begin
            if (bus.tx_valid) begin
              tx_shreg <= {bus.tx_data[DATA_W-2:0], 1'b0};
              miso_q   <= bus.tx_data[DATA_W-1];
              bit_cnt  <= '0;
              state    <= TX_SHIFT;
            end
          end
          TX_SHIFT: begin
            if (!done) begin
              if (bit_cnt == LAST_TX) begin
                miso_q       <= MISO_IDLE;
                rd_addr_seen <= 1'b0;
                done         <= 1'b1;
              end else begin
                miso_q   <= tx_shreg[DATA_W-1];
                tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};
                bit_cnt  <= bit_cnt + CNT_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.MISO     = miso_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign bus.frame_err = frame_err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: an 8-bit and a 16-bit instance driven one at a time.
module tb_spi_slave_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_param_if #(.DATA_W(8))  if8 ();
  spi_slave_param_if #(.DATA_W(16)) if16 ();

  spi_slave_param #(.DATA_W(8), .MISO_IDLE(1'b0)) dut8 (
    .clk(clk), .rst(rst), .bus(if8)
  );
  spi_slave_param #(.DATA_W(16), .MISO_IDLE(1'b0)) dut16 (
    .clk(clk), .rst(rst), .bus(if16)
  );

  localparam logic [31:0] S_IDLE = 0, S_WRITE = 2, S_READ_ADD = 3, S_TX_WAIT = 5;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rxv(input bit u);
    return u ? if16.rx_valid : if8.rx_valid;
  endfunction

  function automatic logic miso(input bit u);
    return u ? if16.MISO : if8.MISO;
  endfunction

  task automatic set_ss(input bit u, input logic v);
    if (u) if16.SS_n = v; else if8.SS_n = v;
  endtask

  task automatic set_mosi(input bit u, input logic v);
    if (u) if16.MOSI = v; else if8.MOSI = v;
  endtask

  // Drops SS_n, spends one edge entering CHK_CMD, then presents nbits frame bits MSB first.
  // Returns at the negedge after the edge that sampled the last presented bit.
  task automatic send_frame(input bit u, input logic [17:0] f, input int fw, input int nbits,
                            output int early, output logic got_last);
    early = 0;
    @(negedge clk);
    set_ss(u, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (rxv(u)) early++;
      set_mosi(u, f[fw-1-i]);
    end
    @(negedge clk);
    got_last = rxv(u);
  endtask

  task automatic end_frame(input bit u);
    set_ss(u, 1'b1);
    set_mosi(u, 1'b0);
    @(negedge clk);
  endtask

  // Called at a negedge while in TX_WAIT; collects dw MISO bits on consecutive cycles.
  task automatic tx_read(input bit u, input logic [15:0] d, input int dw, output logic [15:0] got);
    if (u) begin if16.tx_data = d; if16.tx_valid = 1'b1; end
    else   begin if8.tx_data = d[7:0]; if8.tx_valid = 1'b1; end
    got = '0;
    for (int i = 0; i < dw; i++) begin
      @(negedge clk);
      if (i == 0) begin if16.tx_valid = 1'b0; if8.tx_valid = 1'b0; end
      got = {got[14:0], miso(u)};
    end
  endtask

  int          early;
  logic        got_last;
  logic [15:0] got;

  initial begin
    if8.SS_n = 1'b1;  if8.MOSI = 1'b0;  if8.tx_valid = 1'b0;  if8.tx_data = '0;
    if16.SS_n = 1'b1; if16.MOSI = 1'b0; if16.tx_valid = 1'b0; if16.tx_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rx_data", 32'(if8.rx_data), 32'h000);
    check("rst_rx_valid", 32'(if8.rx_valid), 0);
    check("rst_miso", 32'(if8.MISO), 0);
    check("rst_state", 32'(dut8.state), S_IDLE);
    check("rst_frame_err", 32'(if8.frame_err), 0);
    rst = 1'b0;

    // write-address frame, then extra bits that must be ignored
    send_frame(0, 18'b00_1010_0101, 10, 10, early, got_last);
    check("wa_early_valid", 32'(early), 0);
    check("wa_valid_last", 32'(got_last), 1);
    check("wa_rx_data", 32'(if8.rx_data), 32'h0A5);
    set_mosi(0, 1'b1);
    @(negedge clk);
    check("wa_valid_one_cycle", 32'(if8.rx_valid), 0);
    repeat (3) @(negedge clk);
    check("wa_extra_bits_data", 32'(if8.rx_data), 32'h0A5);
    check("wa_hold_state", 32'(dut8.state), S_WRITE);
    end_frame(0);
    check("wa_idle", 32'(dut8.state), S_IDLE);

    send_frame(0, 18'b01_0011_1100, 10, 10, early, got_last);
    check("wd_valid_last", 32'(got_last), 1);
    check("wd_rx_data", 32'(if8.rx_data), 32'h13C);
    end_frame(0);

    // read address, read data, MISO read-out
    send_frame(0, 18'b10_0001_0000, 10, 10, early, got_last);
    check("ra_rx_data", 32'(if8.rx_data), 32'h210);
    end_frame(0);
    check("ra_seen", 32'(dut8.rd_addr_seen), 1);
    send_frame(0, 18'b11_0101_0101, 10, 10, early, got_last);
    check("rd_valid_last", 32'(got_last), 1);
    check("rd_rx_data", 32'(if8.rx_data), 32'h355);
    check("rd_tx_wait", 32'(dut8.state), S_TX_WAIT);
    tx_read(0, 16'h00C3, 8, got);
    check("rd_miso_bits", 32'(got), 32'h0C3);
    @(negedge clk);
    check("rd_miso_idle", 32'(if8.MISO), 0);
    check("rd_seen_clear", 32'(dut8.rd_addr_seen), 0);
    end_frame(0);
    send_frame(0, 18'b10_1000_0001, 10, 10, early, got_last);
    check("ra2_state", 32'(dut8.state), S_READ_ADD);
    check("ra2_seen", 32'(dut8.rd_addr_seen), 1);
    end_frame(0);

    // abort after five bits of a write frame
    send_frame(0, 18'b00_1111_0000, 10, 5, early, got_last);
    check("ab_no_valid", 32'(early) + 32'(got_last), 0);
    end_frame(0);
    check("ab_frame_err", 32'(if8.frame_err), 32'(ERR_EXP));
    check("ab_rx_valid", 32'(if8.rx_valid), 0);
    check("ab_rx_data", 32'(if8.rx_data), 32'h281);
    check("ab_state", 32'(dut8.state), S_IDLE);
    check("ab_seen_kept", 32'(dut8.rd_addr_seen), 1);
    @(negedge clk);
    check("ab_err_pulse", 32'(if8.frame_err), 0);

    // reset while bit 3 of 0x5A is on MISO
    send_frame(0, 18'b11_0000_0000, 10, 10, early, got_last);
    check("rs_tx_wait", 32'(dut8.state), S_TX_WAIT);
    if8.tx_data = 8'h5A;
    if8.tx_valid = 1'b1;
    @(negedge clk);
    if8.tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rs_bit3", 32'(if8.MISO), 1);
    rst = 1'b1;
    set_ss(0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    check("rs_miso", 32'(if8.MISO), 0);
    check("rs_seen", 32'(dut8.rd_addr_seen), 0);
    check("rs_state", 32'(dut8.state), S_IDLE);
    if8.tx_data = 8'hFF;
    if8.tx_valid = 1'b1;
    @(negedge clk);
    if8.tx_valid = 1'b0;
    @(negedge clk);
    check("rs_txv_ignored", 32'(if8.MISO), 0);
    check("rs_txv_state", 32'(dut8.state), S_IDLE);

    // 16-bit instance
    send_frame(1, {2'b01, 16'hBEEF}, 18, 18, early, got_last);
    check("w16_early_valid", 32'(early), 0);
    check("w16_valid_last", 32'(got_last), 1);
    check("w16_rx_data", 32'(if16.rx_data), 32'h1BEEF);
    end_frame(1);
    send_frame(1, {2'b10, 16'h0040}, 18, 18, early, got_last);
    check("ra16_rx_data", 32'(if16.rx_data), 32'h20040);
    end_frame(1);
    check("ra16_seen", 32'(dut16.rd_addr_seen), 1);
    send_frame(1, {2'b11, 16'h0000}, 18, 18, early, got_last);
    check("rd16_tx_wait", 32'(dut16.state), S_TX_WAIT);
    tx_read(1, 16'h1234, 16, got);
    check("rd16_miso_bits", 32'(got), 32'h1234);
    @(negedge clk);
    check("rd16_miso_idle", 32'(if16.MISO), 0);
    check("rd16_seen_clear", 32'(dut16.rd_addr_seen), 0);
    end_frame(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
